// File: rtl/fp_pkg.sv
// fp_pkg: shared single-precision helpers for the float datapath blocks
// (single_multiplier, adder, float_to_int).
// Contents:
//   - IEEE-754 single field widths, bias and special exponent codes
//   - canonical quiet NaN pattern
//   - 32-bit signed integer limits
//   - 3-bit state encoding shared by the iterative float FSMs
//   - field extraction helpers
package fp_pkg;

  localparam int          EXP_W       = 8;
  localparam int          MANT_W      = 23;
  localparam logic [7:0]  EXP_BIAS    = 8'd127;
  localparam logic [7:0]  EXP_SPECIAL = 8'd255;   // NaN / infinity
  localparam logic [7:0]  EXP_DENORM  = 8'd0;     // zero / denormal
  localparam logic [31:0] CANON_NAN   = 32'h7FC00000;
  localparam logic [31:0] INT_MAX     = 32'h7FFFFFFF;
  localparam logic [31:0] INT_MIN     = 32'h80000000;

  typedef enum logic [2:0] {
    GET_A         = 3'd0,
    UNPACK        = 3'd1,
    SPECIAL_CASES = 3'd2,
    CONVERT       = 3'd3,
    PACK          = 3'd4,
    PUT_Z         = 3'd5
  } fp_state_t;

  function automatic logic float_sign(input logic [31:0] f);
    return f[31];
  endfunction

  function automatic logic [EXP_W-1:0] float_exp(input logic [31:0] f);
    return f[30:23];
  endfunction

  function automatic logic [MANT_W-1:0] float_mant(input logic [31:0] f);
    return f[22:0];
  endfunction

endpackage

// File: rtl/float_to_int.sv
// float_to_int: converts an IEEE-754 single to a 32-bit signed integer,
// rounding toward zero and saturating out-of-range values. The magnitude
// is aligned by an iterative right shift of one bit per cycle.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   input_a[31:0]         float operand
//   input_a_stb/_ack      input handshake (transfer when both high at an edge)
//   output_z[31:0]        signed integer result, held after the handshake
//   output_z_stb/_ack     output handshake (transfer when both high at an edge)
module float_to_int
  import fp_pkg::*;
#(
  parameter logic [31:0] NAN_VALUE = 32'h80000000,
  parameter logic [31:0] POS_SAT   = INT_MAX,
  parameter logic [31:0] NEG_SAT   = INT_MIN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  fp_state_t         state_q, state_d;
  logic [31:0]       a_q, a_d;
  logic              s_q, s_d;
  logic signed [9:0] e_q, e_d;
  // Only the stored 23 fraction bits are kept; the hidden bit is implied.
  logic [22:0]       m_q, m_d;
  logic [31:0]       z_m_q, z_m_d;
  logic signed [9:0] z_e_q, z_e_d;
  logic [31:0]       z_q, z_d;
  logic              ack_q, ack_d;
  logic              stb_q, stb_d;
  logic [31:0]       out_q, out_d;
  logic [7:0]        exp_field;

  assign exp_field = float_exp(a_q);

  // State and datapath registers; reset abandons any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GET_A;
      a_q     <= '0;
      s_q     <= 1'b0;
      e_q     <= '0;
      m_q     <= '0;
      z_m_q   <= '0;
      z_e_q   <= '0;
      z_q     <= '0;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      s_q     <= s_d;
      e_q     <= e_d;
      m_q     <= m_d;
      z_m_q   <= z_m_d;
      z_e_q   <= z_e_d;
      z_q     <= z_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
      out_q   <= out_d;
    end
  end

  // Next-state and datapath logic. The value {1, frac, 8'b0} is the
  // significand scaled by 2^31, so shifting right (31-e) times leaves the
  // integer part; bits falling off the bottom give round-toward-zero.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    s_d     = s_q;
    e_d     = e_q;
    m_d     = m_q;
    z_m_d   = z_m_q;
    z_e_d   = z_e_q;
    z_d     = z_q;
    ack_d   = ack_q;
    stb_d   = stb_q;
    out_d   = out_q;

    case (state_q)
      GET_A: begin
        ack_d = 1'b1;
        if (input_a_stb && ack_q) begin
          a_d     = input_a;
          ack_d   = 1'b0;
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        s_d     = float_sign(a_q);
        e_d     = $signed({2'b00, exp_field}) - $signed({2'b00, EXP_BIAS});
        m_d     = float_mant(a_q);
        state_d = SPECIAL_CASES;
      end

      SPECIAL_CASES: begin
        state_d = PUT_Z;
        if (exp_field == EXP_SPECIAL && m_q != '0) begin
          z_d = NAN_VALUE;
        end else if (exp_field == EXP_SPECIAL) begin
          z_d = s_q ? NEG_SAT : POS_SAT;
        end else if (exp_field == EXP_DENORM || e_q < 0) begin
          z_d = '0;
        end else if (e_q == 10'sd31 && s_q && m_q == '0) begin
          z_d = INT_MIN;
        end else if (e_q >= 10'sd31) begin
          z_d = s_q ? NEG_SAT : POS_SAT;
        end else begin
          z_m_d   = {1'b1, m_q, 8'b0};
          z_e_d   = e_q;
          state_d = CONVERT;
        end
      end

      CONVERT: begin
        if (z_e_q < 10'sd31) begin
          z_m_d = z_m_q >> 1;
          z_e_d = z_e_q + 10'sd1;
        end else begin
          state_d = PACK;
        end
      end

      PACK: begin
        z_d     = s_q ? (~z_m_q + 32'd1) : z_m_q;
        state_d = PUT_Z;
      end

      PUT_Z: begin
        stb_d = 1'b1;
        out_d = z_q;
        if (stb_q && output_z_ack) begin
          stb_d   = 1'b0;
          state_d = GET_A;
        end
      end

      default: begin
        state_d = GET_A;
        ack_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  assign input_a_ack  = ack_q;
  assign output_z_stb = stb_q;
  assign output_z     = out_q;

endmodule

// File: tb/tb_float_to_int.sv
// tb_float_to_int: directed and randomized checks of float_to_int against
// a real-arithmetic reference model.
module tb_float_to_int;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_a = '0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  float_to_int dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Global time bound so a stuck design still ends the run.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference value of a single-precision pattern as a real number.
  function automatic real floatValue(input logic [31:0] bits);
    int  ex;
    real frac, mag;
    ex   = int'(bits[30:23]);
    frac = real'(bits[22:0]);
    if (ex == 0) mag = frac * (2.0 ** (-149));
    else         mag = (1.0 + frac / 8388608.0) * (2.0 ** (ex - 127));
    return bits[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] refConvert(input logic [31:0] bits);
    real v;
    int  iv;
    if (bits[30:23] == 8'hFF && bits[22:0] != 0) return 32'h80000000;
    if (bits[30:23] == 8'hFF) return bits[31] ? 32'h80000000 : 32'h7FFFFFFF;
    v = floatValue(bits);
    if (v >= 2147483648.0)  return 32'h7FFFFFFF;
    if (v <= -2147483648.0) return 32'h80000000;
    iv = $rtoi(v);
    return iv;
  endfunction

  // Cycles from accept to result: 3 for special cases, otherwise one extra
  // cycle per bit position the integer part sits below bit 31.
  function automatic int refLatency(input logic [31:0] bits);
    real mag;
    int  k;
    if (bits[30:23] == 8'hFF) return 3;
    mag = floatValue(bits);
    if (mag < 0.0) mag = -mag;
    if (mag < 1.0 || mag >= 2147483648.0) return 3;
    k = 0;
    while (2.0 ** (k + 1) <= mag) k++;
    return 36 - k;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Offer one word, return the cycles from accept edge until output_z_stb.
  task automatic applyStimulus(input logic [31:0] value, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (input_a_ack !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", {31'b0, input_a_ack}, 32'd1);
    input_a     = value;
    input_a_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    input_a_stb = 1'b0;
    input_a     = $urandom;
    lat = 0;
    while (output_z_stb !== 1'b1 && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  // Check result and latency, optionally stall, then complete the handshake.
  task automatic checkOutput(input string tag, input logic [31:0] expZ, input int expLat,
                             input int lat, input int holdCycles);
    logic [31:0] held;
    check({tag, "_stb"}, {31'b0, output_z_stb}, 32'd1);
    check({tag, "_z"}, output_z, expZ);
    check({tag, "_lat"}, lat, expLat);
    held = output_z;
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      check({tag, "_hold_stb"}, {31'b0, output_z_stb}, 32'd1);
      check({tag, "_hold_z"}, output_z, held);
      check({tag, "_hold_ack"}, {31'b0, input_a_ack}, 32'd0);
    end
    output_z_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    output_z_ack = 1'b0;
    check({tag, "_stb_drop"}, {31'b0, output_z_stb}, 32'd0);
    check({tag, "_z_keep"}, output_z, expZ);
  endtask

  task automatic convertOne(input string tag, input logic [31:0] value, input logic [31:0] expZ,
                            input int expLat, input int holdCycles);
    int lat;
    applyStimulus(value, lat);
    checkOutput(tag, expZ, expLat, lat, holdCycles);
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [31:0] r;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {31'b0, input_a_ack}, 32'd0);
    check("rst_stb", {31'b0, output_z_stb}, 32'd0);
    check("rst_z", output_z, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ack_rise", {31'b0, input_a_ack}, 32'd1);

    // Directed values
    convertOne("f3p75",   32'h40700000, 32'h00000003, 35, 0);
    convertOne("fm2p5",   32'hC0200000, 32'hFFFFFFFE, 35, 0);
    convertOne("f2p30",   32'h4E800000, 32'h40000000, 6, 0);
    convertOne("f1p0",    32'h3F800000, 32'h00000001, 36, 0);
    convertOne("f2p31",   32'h4F000000, 32'h7FFFFFFF, 3, 0);
    convertOne("fm2p31",  32'hCF000000, 32'h80000000, 3, 0);
    convertOne("fminf",   32'hFF800000, 32'h80000000, 3, 0);
    convertOne("fpinf",   32'h7F800000, 32'h7FFFFFFF, 3, 0);
    convertOne("fnan",    CANON_NAN,    32'h80000000, 3, 0);
    convertOne("f0p5",    32'h3F000000, 32'h00000000, 3, 0);
    convertOne("fmdenorm",32'h80000001, 32'h00000000, 3, 0);
    convertOne("fmzero",  32'h80000000, 32'h00000000, 3, 0);
    convertOne("fmax",    32'h4EFFFFFF, 32'h7FFFFF80, 6, 0);

    // Product of 3.0 x -4.0 as delivered by single_multiplier, then again with backpressure
    convertOne("fm12",    32'hC1400000, 32'hFFFFFFF4, 33, 0);
    convertOne("fm12_bp", 32'hC1400000, 32'hFFFFFFF4, 33, 20);

    // Reset during convert abandons the operation
    applyStimulus(32'h3F800000, lat);
    check("pre_rst_lat", lat, 36);
    output_z_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    output_z_ack = 1'b0;
    input_a     = 32'h3F800000;
    input_a_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    input_a_stb = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ack", {31'b0, input_a_ack}, 32'd0);
    check("mid_rst_stb", {31'b0, output_z_stb}, 32'd0);
    @(negedge clk);
    check("mid_rst_ack_rise", {31'b0, input_a_ack}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (output_z_stb === 1'b1) seen++;
    end
    check("mid_rst_no_stb", seen, 0);
    convertOne("f10p0", 32'h41200000, 32'h0000000A, 33, 0);

    // Randomized values against the reference model
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      if (i % 2 == 0) r[30:23] = 8'(120 + $urandom_range(0, 40));
      convertOne($sformatf("rand%0d_%h", i, r), r, refConvert(r), refLatency(r), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
